// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//   MEM-stage data-memory access unit. It turns a load/store request from the
//   control decoder into a single registered bus transaction, holds the
//   pipeline while the transaction runs, and returns the aligned and extended
//   load result. Misaligned accesses are reported as AdEL/AdES and are never
//   sent to the bus.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   memRead, memWrite        load / store request (both set = load only)
//   readDataSelect           load width  (00 word, 01 half, 10 byte, 11 word)
//   writeDataSelect          store width (same encoding)
//   ldUnsigned               1 = zero-extend byte/half loads, 0 = sign-extend
//   addr, storeData          byte address and store value
//   flush                    kills the request while the FSM is IDLE
//   dmem_*                   registered bus request; dmem_ready/dmem_rdata back
//   loadData                 registered load result
//   stall, done              pipeline hold / one-cycle completion pulse
//   addrErr, addrErrIsStore  misaligned access, 1 = store (AdES)
//   badVAddr                 faulting address while addrErr = 1
//   state_dbg                current FSM state (0 IDLE, 1 REQ, 2 RESP)
//
// Bus handshake: dmem_req rises on the edge that leaves IDLE and the request
// fields (we, addr, be, wdata) stay constant until the slave raises
// dmem_ready for one cycle while dmem_req = 1; dmem_rdata is sampled in that
// cycle and dmem_req drops on the following edge. A transfer therefore
// completes in exactly the cycle where dmem_req and dmem_ready are both 1.
// -----------------------------------------------------------------------------
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  readDataSelect,
    input  logic [1:0]  writeDataSelect,
    input  logic        ldUnsigned,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] loadData,
    output logic        stall,
    output logic        done,
    output logic        addrErr,
    output logic        addrErrIsStore,
    output logic [31:0] badVAddr,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] state, next_state;

    // Request decode (only meaningful while IDLE). A simultaneous read and
    // write is treated as a read, so the width comes from readDataSelect.
    logic        is_read, is_write, any_req;
    logic [1:0]  width_sel;
    logic        is_byte, is_half, aligned, access;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // Load formatting information captured when the request is issued.
    logic        rd_q, ld_byte_q, ld_half_q, ld_uns_q;
    logic [1:0]  ld_lane_q;
    logic [31:0] load_fmt;

    assign is_read   = memRead;
    assign is_write  = memWrite & ~memRead;
    assign any_req   = memRead | memWrite;
    assign width_sel = is_read ? readDataSelect : writeDataSelect;
    assign is_byte   = (width_sel == 2'b10);
    assign is_half   = (width_sel == 2'b01);
    assign aligned   = is_byte | (is_half & ~addr[0]) |
                       (~is_byte & ~is_half & (addr[1:0] == 2'b00));
    assign access    = any_req & ~flush & aligned;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = storeData;
        if (is_byte) begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{storeData[7:0]}};
        end else if (is_half) begin
            be_next    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{storeData[15:0]}};
        end
    end

    always_comb begin
        load_fmt = dmem_rdata;
        if (ld_byte_q) begin
            case (ld_lane_q)
                2'd0:    load_fmt[7:0] = dmem_rdata[7:0];
                2'd1:    load_fmt[7:0] = dmem_rdata[15:8];
                2'd2:    load_fmt[7:0] = dmem_rdata[23:16];
                default: load_fmt[7:0] = dmem_rdata[31:24];
            endcase
            load_fmt[31:8] = ld_uns_q ? 24'd0 : {24{load_fmt[7]}};
        end else if (ld_half_q) begin
            load_fmt[15:0]  = ld_lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
            load_fmt[31:16] = ld_uns_q ? 16'd0 : {16{load_fmt[15]}};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; flush only matters in IDLE so a started transfer
    // always runs to completion.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (access) next_state = S_REQ;
            S_REQ:   if (dmem_ready) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall          = 1'b0;
        done           = 1'b0;
        addrErr        = 1'b0;
        addrErrIsStore = 1'b0;
        badVAddr       = 32'd0;
        case (state)
            S_IDLE: begin
                stall   = access;
                addrErr = any_req & ~flush & ~aligned;
                if (addrErr) begin
                    addrErrIsStore = is_write;
                    badVAddr       = addr;
                end
            end
            S_REQ:   stall = 1'b1;
            S_RESP:  done  = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

    // Bus and load-result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            loadData   <= 32'd0;
            rd_q       <= 1'b0;
            ld_byte_q  <= 1'b0;
            ld_half_q  <= 1'b0;
            ld_uns_q   <= 1'b0;
            ld_lane_q  <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_write;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= be_next;
                        // Reads drive zero write data so the bus is quiet.
                        dmem_wdata <= is_write ? wdata_next : 32'd0;
                        rd_q       <= is_read;
                        ld_byte_q  <= is_byte;
                        ld_half_q  <= is_half;
                        ld_uns_q   <= ldUnsigned;
                        ld_lane_q  <= addr[1:0];
                    end
                end
                S_REQ: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (rd_q) loadData <= load_fmt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//   Directed bench for mem_access. Inputs change on the falling edge and
//   outputs are sampled 1 ns later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite, ldUnsigned, flush, dmem_ready;
    logic [1:0]  readDataSelect, writeDataSelect;
    logic [31:0] addr, storeData, dmem_rdata;
    logic        dmem_req, dmem_we, stall, done, addrErr, addrErrIsStore;
    logic [31:0] dmem_addr, dmem_wdata, loadData, badVAddr;
    logic [3:0]  dmem_be;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access dut (
        .clk(clk), .rst(rst),
        .memRead(memRead), .memWrite(memWrite),
        .readDataSelect(readDataSelect), .writeDataSelect(writeDataSelect),
        .ldUnsigned(ldUnsigned), .addr(addr), .storeData(storeData),
        .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .loadData(loadData), .stall(stall), .done(done),
        .addrErr(addrErr), .addrErrIsStore(addrErrIsStore),
        .badVAddr(badVAddr), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        memRead = 0; memWrite = 0; readDataSelect = 0; writeDataSelect = 0;
        ldUnsigned = 0; addr = 0; storeData = 0; flush = 0;
    endtask

    // One complete transaction. 'delay' = REQ cycles with dmem_ready low before
    // the ready cycle. Bus fields are checked in every REQ cycle.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [1:0] rsel, input logic [1:0] wsel,
                              input logic uns, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rdata,
                              input int delay, input int exp_stall,
                              input logic exp_we, input logic [3:0] exp_be,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_load);
        int stall_cnt;
        @(negedge clk);
        memRead = rd; memWrite = wr; readDataSelect = rsel; writeDataSelect = wsel;
        ldUnsigned = uns; addr = a; storeData = sd;
        #1;
        check({tag, "_idle_stall"}, stall, 1);
        check({tag, "_idle_err"}, addrErr, 0);
        stall_cnt = 1;
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i <= delay; i++) begin
            dmem_ready = (i == delay);
            dmem_rdata = (i == delay) ? rdata : 32'hFFFF_FFFF;
            #1;
            check({tag, "_state_req"}, state_dbg, 1);
            check({tag, "_req"}, dmem_req, 1);
            check({tag, "_we"}, dmem_we, exp_we);
            check({tag, "_be"}, dmem_be, exp_be);
            check({tag, "_addr"}, dmem_addr, exp_addr);
            if (exp_we) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
            if (stall) stall_cnt++;
            @(negedge clk);
        end
        dmem_ready = 0; dmem_rdata = 0;
        #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_resp_stall"}, stall, 0);
        check({tag, "_resp_req"}, dmem_req, 0);
        check({tag, "_load"}, loadData, exp_load);
        check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
        @(negedge clk);
        #1;
        check({tag, "_done_low"}, done, 0);
        check({tag, "_back_idle"}, state_dbg, 0);
    endtask

    initial begin
        idle_inputs();
        dmem_ready = 0; dmem_rdata = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_state", state_dbg, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_be", dmem_be, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_load", loadData, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);

        //           tag    rd wr rsel   wsel   uns addr          storeData     rdata         dly st we be       addr          wdata         load
        run_access("lb",    1, 0, 2'b10, 2'b00, 0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 2, 0, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80);
        run_access("sh",    0, 1, 2'b00, 2'b01, 0, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,         0, 2, 1, 4'b1100, 32'h0000_2000, 32'hBEEF_BEEF, 32'hFFFF_FF80);
        run_access("sb",    0, 1, 2'b00, 2'b10, 0, 32'h0000_2001, 32'h1234_5678, 32'h0,         1, 3, 1, 4'b0010, 32'h0000_2000, 32'h7878_7878, 32'hFFFF_FF80);
        run_access("sw",    0, 1, 2'b00, 2'b11, 0, 32'h0000_2004, 32'h1122_3344, 32'h0,         0, 2, 1, 4'b1111, 32'h0000_2004, 32'h1122_3344, 32'hFFFF_FF80);
        run_access("lw_dly",1, 0, 2'b00, 2'b00, 0, 32'h0000_3000, 32'h0,        32'hCAFE_F00D, 3, 5, 0, 4'b1111, 32'h0000_3000, 32'h0,        32'hCAFE_F00D);
        run_access("lh",    1, 0, 2'b01, 2'b00, 0, 32'h0000_0010, 32'h0,        32'h1234_8001, 0, 2, 0, 4'b0011, 32'h0000_0010, 32'h0,        32'hFFFF_8001);
        run_access("lbu",   1, 0, 2'b10, 2'b00, 1, 32'h0000_0021, 32'h0,        32'h0000_AB00, 0, 2, 0, 4'b0010, 32'h0000_0020, 32'h0,        32'h0000_00AB);
        run_access("rdwr",  1, 1, 2'b00, 2'b10, 0, 32'h0000_7000, 32'h5555_5555, 32'h55AA_55AA, 0, 2, 0, 4'b1111, 32'h0000_7000, 32'h0,        32'h55AA_55AA);
        run_access("lhu",   1, 0, 2'b01, 2'b00, 1, 32'h0000_4002, 32'h0,        32'h9ABC_0000, 0, 2, 0, 4'b1100, 32'h0000_4000, 32'h0,        32'h0000_9ABC);

        // Misaligned load word
        @(negedge clk);
        memRead = 1; readDataSelect = 2'b00; addr = 32'h0000_3002;
        #1;
        check("adel_err", addrErr, 1);
        check("adel_is_store", addrErrIsStore, 0);
        check("adel_badva", badVAddr, 32'h0000_3002);
        check("adel_stall", stall, 0);
        @(negedge clk);
        #1;
        check("adel_no_req", dmem_req, 0);
        check("adel_state", state_dbg, 0);
        // Misaligned store word
        idle_inputs();
        memWrite = 1; writeDataSelect = 2'b00; addr = 32'h0000_3001;
        #1;
        check("ades_err", addrErr, 1);
        check("ades_is_store", addrErrIsStore, 1);
        check("ades_badva", badVAddr, 32'h0000_3001);
        // Misaligned half, then byte at an odd address (always aligned)
        idle_inputs();
        memRead = 1; readDataSelect = 2'b01; addr = 32'h0000_0005;
        #1;
        check("half_odd_err", addrErr, 1);
        readDataSelect = 2'b10;
        #1;
        check("byte_odd_err", addrErr, 0);
        check("byte_odd_stall", stall, 1);
        // Flush suppresses both the access and the error
        flush = 1;
        #1;
        check("flush_stall", stall, 0);
        readDataSelect = 2'b00; addr = 32'h0000_5002;
        #1;
        check("flush_err", addrErr, 0);
        addr = 32'h0000_5000;
        @(negedge clk);
        #1;
        check("flush_no_req", dmem_req, 0);
        check("flush_state", state_dbg, 0);

        // Reset while in REQ
        idle_inputs();
        memRead = 1; readDataSelect = 2'b00; addr = 32'h0000_6000;
        @(negedge clk);
        idle_inputs();
        #1;
        check("rstreq_in_req", dmem_req, 1);
        rst = 1;
        dmem_ready = 1; dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        rst = 0; dmem_ready = 0; dmem_rdata = 0;
        #1;
        check("rstreq_state", state_dbg, 0);
        check("rstreq_req", dmem_req, 0);
        check("rstreq_load", loadData, 0);
        check("rstreq_done", done, 0);
        @(negedge clk);
        #1;
        check("rstreq_done_later", done, 0);
        check("rstreq_state_later", state_dbg, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so a broken DUT cannot stall the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected end within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
